display_scan_axil: RTL and testbench
====================================

# display_scan_axil

AXI4-Lite slave that drives a time-multiplexed, common-anode 7-segment display of parametrised digit count. It holds per-digit hex nibbles, a decimal-point mask, a refresh divider and a 16-level brightness control. It sits in the board IP repository as the general successor to the fixed four-register display controller, behind the PS AXI interconnect.

## Interface
- NUM_DIGITS, 8: digits driven; legal range 1..32.
- DEFAULT_DIV, 49999: reset value of the DIV register, in clocks per digit slot minus 1.
- C_S_AXI_DATA_WIDTH, 32: AXI data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; covers 0x00..0x1C.

Ports:
- ACLK  in  1  system clock.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY: standard AXI4-Lite write channels. AWPROT is ignored.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite read channels. ARPROT is ignored.
- an_n  out  NUM_DIGITS  anode enables, active low, at most one low.
- seg_n  out  7  segments a..g on bits 0..6, active low.
- dp_n  out  1  decimal point, active low.

## Operation
Register map, word-aligned. Address bits [1:0] are ignored.
- 0x00 CTRL, RW: [0] EN, [7:4] BRIGHT. Reset 0x000000F0.
- 0x04 DIV, RW: [15:0]. Reset DEFAULT_DIV.
- 0x08 DP, RW: [NUM_DIGITS-1:0]. Reset 0.
- 0x0C STATUS, RO: [4:0] current digit index, [8] FRAME bit, which toggles each time the index wraps to 0. Reset 0.
- 0x10+4k DATA_k, RW, k = 0..3: nibble j of DATA_k is digit 8k+j. Reset 0.
  - Words with 8k >= NUM_DIGITS are unmapped.
  - Nibbles and DP bits beyond NUM_DIGITS read as 0 and are not stored.

AXI write rules:
- AWREADY and WREADY assert together for exactly one cycle, when AWVALID, WVALID and !BVALID are all true. The address and data are accepted in the same cycle.
- WSTRB byte enables are honoured per byte.
- BRESP is OKAY for mapped RW addresses. It is SLVERR for STATUS or unmapped addresses, and the write is dropped.

AXI read rules:
- ARREADY asserts for one cycle when ARVALID and !RVALID.
- RDATA is registered. RRESP is SLVERR with RDATA 0 for unmapped addresses, OKAY otherwise.

Scan engine:
- slot_cnt is 16 bits. It increments every clock while EN=1.
- When slot_cnt >= DIV, slot_cnt returns to 0 and the index advances. The index wraps from NUM_DIGITS-1 to 0.
- The ">=" comparison covers a DIV write below the current count: the slot ends on the next cycle.
- Dead time: while slot_cnt == 0, all an_n are high. This suppresses ghosting.
- Brightness: pwm_cnt is a free-running 4-bit counter. The selected anode is driven low only when pwm_cnt <= BRIGHT. BRIGHT=15 gives full on; BRIGHT=0 gives a 1/16 duty.
- Decoder: hex 0..F maps to the standard glyphs "0123456789AbCdEF".
  - Example encodings, active high before inversion: 0 = 0x3F, 8 = 0x7F, A = 0x77, F = 0x71.
  - dp_n = ~DP[index].
- EN=0: slot_cnt, pwm_cnt and the index hold at 0. an_n, seg_n and dp_n are forced to all ones.

## Timing
- Reset values:
  - an_n, seg_n, dp_n: all ones.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID: 0.
  - BRESP, RRESP, RDATA: 0.
  - Registers take their listed reset values.
- Write latency: BVALID asserts the cycle after the handshake and holds until BREADY.
- A register write takes effect on the scan path in that same following cycle.
- Read latency: RVALID asserts the cycle after the ARREADY handshake and holds until RREADY.
- Simultaneous read and write of the same register: the read returns the pre-write value.
- Display outputs are registered, one cycle after the index, slot_cnt and pwm_cnt values they reflect.
- With DIV=D and BRIGHT=15, each digit's anode is low for D cycles per slot of D+1 cycles. Frame period is NUM_DIGITS·(D+1) clocks.
- DIV=0: every slot is dead time, so all anodes stay off while the index still cycles each clock.
- ARESET asserted mid-transaction: all outputs and handshakes return to reset values asynchronously. Any pending response is lost.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C -> 0xF0, DEFAULT_DIV, 0, 0, all with RRESP OKAY. an_n, seg_n and dp_n all ones.
- NUM_DIGITS=8, DIV=3. Write DATA_0=0x76543210, then CTRL=0xF1 -> slots of 4 cycles each.
  - Slot 0: an_n=0xFE with seg_n=~0x3F.
  - Slot 1: an_n=0xFD with seg_n=~0x06.
  - One all-off cycle at the start of each slot.
  - FRAME toggles every 32 cycles.
- Write DATA_0 with WSTRB=0b0010 and WDATA=0xAAAAAAAA over 0x76543210 -> readback 0x7654AA10.
- Write 0x0C and 0x1C with NUM_DIGITS=8 -> BRESP SLVERR, register unchanged. Read 0x1C -> SLVERR, RDATA 0.
- BRIGHT=3, EN=1, DIV=31 -> within each digit slot the anode is low in exactly 4 of every 16 cycles, excluding dead time.
- Mid-scan with DIV=1000 and slot_cnt near 900, write DIV=10 -> index advances the next cycle. Then assert ARESET -> outputs all ones, STATUS reads 0.

Source files
------------

// File: rtl/display_scan_axil_if.sv
// AXI4-Lite bus bundle used by display_scan_axil.
interface display_scan_axil_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/display_scan_axil.sv
// AXI4-Lite controlled, time-multiplexed common-anode 7-segment display driver
// with per-digit hex nibbles, decimal points, refresh divider and 16-level PWM.
module display_scan_axil #(
    parameter int NUM_DIGITS         = 8,
    parameter int DEFAULT_DIV        = 49999,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    display_scan_axil_if.slave    s_axi,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word index (address bits [4:2]) of each register.
    localparam logic [2:0] SEL_CTRL   = 3'd0;
    localparam logic [2:0] SEL_DIV    = 3'd1;
    localparam logic [2:0] SEL_DP     = 3'd2;
    localparam logic [2:0] SEL_STATUS = 3'd3;

    // DATA_k lives at index 4+k and exists only if it holds at least one digit.
    function automatic logic data_mapped(input logic [2:0] sel);
        return sel[2] && (int'(sel[1:0]) * 8 < NUM_DIGITS);
    endfunction

    // Hex digit to segments a..g on bits 0..6, active high.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Bus-side state
    logic                            awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]                      bresp_q, rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rd_word;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr, rd_addr;
    logic [2:0]                      wr_sel, rd_sel;
    logic                            wr_fire, wr_ok, rd_fire, rd_ok;

    // Register file
    logic                            en_q;
    logic [3:0]                      bright_q;
    logic [15:0]                     div_q;
    logic [NUM_DIGITS-1:0]           dp_q;
    logic [4*NUM_DIGITS-1:0]         nib_q;

    // Scan engine
    logic [15:0]                     slot_cnt;
    logic [3:0]                      pwm_cnt;
    logic [4:0]                      digit_idx;
    logic                            frame_q;
    logic [3:0]                      cur_nib;
    logic                            cur_dp;
    logic [NUM_DIGITS-1:0]           sel_an;
    logic                            lit;

    assign wr_addr = s_axi.awaddr;
    assign rd_addr = s_axi.araddr;
    assign wr_sel  = wr_addr[4:2];
    assign rd_sel  = rd_addr[4:2];
    assign wr_fire = awready_q && s_axi.awvalid && s_axi.wvalid;
    assign rd_fire = arready_q && s_axi.arvalid;
    assign wr_ok   = (wr_sel <= SEL_DP) || data_mapped(wr_sel);
    assign rd_ok   = (rd_sel <= SEL_STATUS) || data_mapped(rd_sel);

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    // Protection bits and byte offset carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, wr_addr[1:0], rd_addr[1:0]};

    // Write address/data accept pulse and write response.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge
    // values; this is also why a same-cycle read returns the pre-write contents.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= !awready_q && s_axi.awvalid && s_axi.wvalid && !bvalid_q;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register updates with per-byte strobes; STATUS and unmapped writes are dropped.
    // NOTE: the digit nibbles are a handful of flops, not a RAM, so they are reset
    // like every other register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            en_q     <= 1'b0;
            bright_q <= 4'hF;
            div_q    <= 16'(DEFAULT_DIV);
            dp_q     <= '0;
            nib_q    <= '0;
        end else if (wr_fire && wr_ok) begin
            case (wr_sel)
                SEL_CTRL: begin
                    if (s_axi.wstrb[0]) begin
                        en_q     <= s_axi.wdata[0];
                        bright_q <= s_axi.wdata[7:4];
                    end
                end
                SEL_DIV: begin
                    if (s_axi.wstrb[0]) div_q[7:0]  <= s_axi.wdata[7:0];
                    if (s_axi.wstrb[1]) div_q[15:8] <= s_axi.wdata[15:8];
                end
                SEL_DP: begin
                    for (int b = 0; b < NUM_DIGITS; b++)
                        if (s_axi.wstrb[b/8]) dp_q[b] <= s_axi.wdata[b];
                end
                default: begin
                    for (int d = 0; d < NUM_DIGITS; d++)
                        if (wr_sel == 3'(4 + d/8) && s_axi.wstrb[(d%8)/2])
                            nib_q[4*d +: 4] <= s_axi.wdata[4*(d%8) +: 4];
                end
            endcase
        end
    end

    // Read-data mux; unstored digits and DP bits read as zero.
    // NOTE: default assignment first so no path leaves rd_word unassigned (no latch).
    always_comb begin
        rd_word = '0;
        case (rd_sel)
            SEL_CTRL: begin
                rd_word[0]   = en_q;
                rd_word[7:4] = bright_q;
            end
            SEL_DIV:    rd_word[15:0] = div_q;
            SEL_DP:     rd_word[NUM_DIGITS-1:0] = dp_q;
            SEL_STATUS: begin
                rd_word[4:0] = digit_idx;
                rd_word[8]   = frame_q;
            end
            default: begin
                for (int d = 0; d < NUM_DIGITS; d++)
                    if (rd_sel == 3'(4 + d/8))
                        rd_word[4*(d%8) +: 4] = nib_q[4*d +: 4];
            end
        endcase
    end

    // Read address accept pulse and registered read response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            arready_q <= !arready_q && s_axi.arvalid && !rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                rdata_q  <= rd_ok ? rd_word : '0;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Slot timer, PWM phase and digit index; ">=" ends a slot at once if DIV drops below the count.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            slot_cnt  <= '0;
            pwm_cnt   <= '0;
            digit_idx <= '0;
            frame_q   <= 1'b0;
        end else if (!en_q) begin
            slot_cnt  <= '0;
            pwm_cnt   <= '0;
            digit_idx <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_cnt >= div_q) begin
                slot_cnt <= '0;
                if (digit_idx == 5'(NUM_DIGITS - 1)) begin
                    digit_idx <= '0;
                    frame_q   <= ~frame_q;
                end else begin
                    digit_idx <= digit_idx + 5'd1;
                end
            end else begin
                slot_cnt <= slot_cnt + 16'd1;
            end
        end
    end

    // Select the current digit's nibble, DP bit and anode; anode lit outside dead time when PWM allows.
    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        sel_an  = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_idx == 5'(d)) begin
                cur_nib   = nib_q[4*d +: 4];
                cur_dp    = dp_q[d];
                sel_an[d] = 1'b0;
            end
        end
        lit = (slot_cnt != 16'd0) && (pwm_cnt <= bright_q);
    end

    // Registered display outputs, blanked while the scan is disabled.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            an_n  <= '1;
            seg_n <= '1;
            dp_n  <= 1'b1;
        end else if (!en_q) begin
            an_n  <= '1;
            seg_n <= '1;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= lit ? sel_an : '1;
            seg_n <= ~hex_glyph(cur_nib);
            dp_n  <= ~cur_dp;
        end
    end
endmodule

// File: tb/tb_display_scan_axil.sv
// Directed self-checking bench for display_scan_axil (8 digits).
module tb_display_scan_axil;
    localparam int N = 8;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [N-1:0] an_n;
    logic [6:0]   seg_n;
    logic         dp_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd, s1, s2, s3;
    logic [1:0]  resp;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    int          dd, lows, run, max_run, multi, lit_cnt;

    logic [6:0] glyph [0:7] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    display_scan_axil_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    display_scan_axil #(
        .NUM_DIGITS(N),
        .DEFAULT_DIV(49999),
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .s_axi (bus),
        .an_n  (an_n),
        .seg_n (seg_n),
        .dp_n  (dp_n)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] br);
        int n;
        @(negedge ACLK);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("awready_seen", bus.awready, 1);
        check("wready_with_awready", bus.wready, bus.awready);
        @(negedge ACLK);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("awready_pulse", bus.awready, 0);
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("bvalid_seen", bus.bvalid, 1);
        br = bus.bresp;
        bus.bready = 1'b1;
        @(negedge ACLK);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] rr);
        int n;
        @(negedge ACLK);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("arready_seen", bus.arready, 1);
        @(negedge ACLK);
        bus.arvalid = 1'b0;
        check("arready_pulse", bus.arready, 0);
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("rvalid_seen", bus.rvalid, 1);
        data = bus.rdata;
        rr   = bus.rresp;
        bus.rready = 1'b1;
        @(negedge ACLK);
        bus.rready = 1'b0;
    endtask

    initial begin
        ARESET      = 1'b1;
        bus.awaddr  = '0;  bus.awprot = '0;  bus.awvalid = 1'b0;
        bus.wdata   = '0;  bus.wstrb  = '0;  bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;  bus.arprot = '0;  bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        repeat (3) @(negedge ACLK);

        // Reset state
        check("rst_an", an_n, 8'hFF);
        check("rst_seg", seg_n, 7'h7F);
        check("rst_dp", dp_n, 1);
        check("rst_handshakes", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 0);
        check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 0);
        @(negedge ACLK);
        ARESET = 1'b0;

        axi_read(5'h00, rd, resp); check("ctrl_rst", rd, 32'h0000_00F0); check("ctrl_rresp", resp, 0);
        axi_read(5'h04, rd, resp); check("div_rst", rd, 32'd49999);      check("div_rresp", resp, 0);
        axi_read(5'h08, rd, resp); check("dp_rst", rd, 0);               check("dp_rresp", resp, 0);
        axi_read(5'h0C, rd, resp); check("status_rst", rd, 0);           check("status_rresp", resp, 0);

        // Basic scan: DIV=3, digits show 0..7, DP on digit 1, full brightness
        axi_write(5'h04, 32'd3, 4'hF, resp);          check("div_bresp", resp, 0);
        axi_write(5'h10, 32'h7654_3210, 4'hF, resp);  check("data0_bresp", resp, 0);
        axi_write(5'h08, 32'h0000_0002, 4'hF, resp);  check("dp_bresp", resp, 0);
        axi_write(5'h00, 32'h0000_00F1, 4'hF, resp);  check("ctrl_bresp", resp, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            if ((i + 1) % 4 == 0) begin
                check("trace_dead", an_n, 8'hFF);
            end else begin
                dd      = ((i + 1) / 4) % 8;
                exp_an  = ~(8'h01 << dd);
                exp_seg = ~glyph[dd];
                exp_dp  = (dd == 1) ? 1'b0 : 1'b1;
                check("trace_an", an_n, exp_an);
                check("trace_seg", seg_n, exp_seg);
                check("trace_dp", dp_n, exp_dp);
            end
        end

        // FRAME toggles once per 32-cycle frame; one slot later the index is +1
        axi_read(5'h0C, s1, resp);
        repeat (28) @(negedge ACLK);
        axi_read(5'h0C, s2, resp);
        axi_read(5'h0C, s3, resp);
        check("frame_idx_same", s2[4:0], s1[4:0]);
        exp_dp = ~s1[8];
        check("frame_toggle", s2[8], exp_dp);
        check("slot_idx_next", s3[4:0], (s2[4:0] + 5'd1) % 5'd8);

        // Byte strobe: only byte 1 replaced
        axi_write(5'h10, 32'hAAAA_AAAA, 4'b0010, resp); check("strb_bresp", resp, 0);
        axi_read(5'h10, rd, resp); check("strb_readback", rd, 32'h7654_AA10);

        // Error responses
        axi_write(5'h0C, 32'hFFFF_FFFF, 4'hF, resp); check("status_wr_slverr", resp, 2'b10);
        axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, resp); check("unmapped_wr_slverr", resp, 2'b10);
        axi_read(5'h1C, rd, resp); check("unmapped_rd_resp", resp, 2'b10); check("unmapped_rd_data", rd, 0);
        axi_read(5'h14, rd, resp); check("data1_rd_resp", resp, 2'b10); check("data1_rd_data", rd, 0);
        axi_read(5'h0C, rd, resp); check("status_reserved_zero", rd & 32'hFFFF_FEE0, 0); check("status_rd_okay", resp, 0);
        axi_read(5'h04, rd, resp); check("div_unchanged", rd, 3);
        axi_read(5'h10, rd, resp); check("data0_unchanged", rd, 32'h7654_AA10);
        axi_read(5'h08, rd, resp); check("dp_unchanged", rd, 2);

        // EN=0 blanks everything and parks the index
        axi_write(5'h00, 32'h0000_00F0, 4'hF, resp);
        lit_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            if (an_n !== 8'hFF || seg_n !== 7'h7F || dp_n !== 1'b1) lit_cnt++;
        end
        check("en0_blank_cycles", lit_cnt, 0);
        axi_read(5'h0C, rd, resp); check("en0_idx", rd[4:0], 0);

        // BRIGHT=3, DIV=31: 7 lit cycles per 32-cycle slot, longest run 4, one anode at most
        axi_write(5'h04, 32'd31, 4'hF, resp);
        axi_write(5'h00, 32'h0000_0031, 4'hF, resp);
        lows = 0; run = 0; max_run = 0; multi = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge ACLK);
            if ($countones(~an_n) > 1) multi++;
            if (an_n !== 8'hFF) begin
                lows++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("pwm_low_cycles", lows, 14);
        check("pwm_max_run", max_run, 4);
        check("pwm_one_anode", multi, 0);

        // DIV=0: anodes stay off, index steps every clock
        axi_write(5'h04, 32'd0, 4'hF, resp);
        lit_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge ACLK);
            if (an_n !== 8'hFF) lit_cnt++;
        end
        check("div0_dark", lit_cnt, 0);
        axi_read(5'h0C, s1, resp);
        axi_read(5'h0C, s2, resp);
        check("div0_idx_step", s2[4:0], (s1[4:0] + 5'd4) % 5'd8);

        // Shrinking DIV below the running count ends the slot on the next cycle
        axi_write(5'h00, 32'h0000_00F0, 4'hF, resp);
        axi_write(5'h04, 32'd1000, 4'hF, resp);
        axi_write(5'h00, 32'h0000_00F1, 4'hF, resp);
        repeat (880) @(negedge ACLK);
        axi_read(5'h0C, rd, resp); check("long_slot_idx", rd[4:0], 0);
        axi_write(5'h04, 32'd10, 4'hF, resp);
        axi_read(5'h0C, rd, resp); check("div_shrink_idx", rd[4:0], 1);

        // Asynchronous reset in the middle of a write
        @(negedge ACLK);
        bus.awaddr = 5'h04; bus.wdata = 32'd5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge ACLK);
        check("pre_rst_awready", bus.awready, 1);
        #2 ARESET = 1'b1;
        #1;
        check("arst_an", an_n, 8'hFF);
        check("arst_seg", seg_n, 7'h7F);
        check("arst_dp", dp_n, 1);
        check("arst_handshakes", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 0);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        axi_read(5'h0C, rd, resp); check("arst_status", rd, 0);
        axi_read(5'h04, rd, resp); check("arst_div", rd, 32'd49999);
        axi_read(5'h00, rd, resp); check("arst_ctrl", rd, 32'h0000_00F0);
        axi_read(5'h10, rd, resp); check("arst_data0", rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
